// File: rtl/pong_pkg.sv
// Shared constants for the pong match logic: phase codes, player codes and
// parameter defaults used by match_ctl and its timer.
package pong_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [1:0] player_t;

  localparam logic [2:0] PH_NEWGAME    = 3'd0;
  localparam logic [2:0] PH_WAIT_SERVE = 3'd1;
  localparam logic [2:0] PH_RALLY      = 3'd2;
  localparam logic [2:0] PH_POINT      = 3'd3;
  localparam logic [2:0] PH_PAUSE      = 3'd4;
  localparam logic [2:0] PH_OVER       = 3'd5;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER_P1   = 2'b01;
  localparam logic [1:0] PLAYER_P2   = 2'b10;

  localparam int DEFAULT_PAUSE_CYCLES  = 65000000;
  localparam int DEFAULT_SERVE_TIMEOUT = 325000000;
  localparam int DEFAULT_CNT_W         = 29;

  // Scores are 2 bits wide, so a reachable winning score lies in 1..3.
  localparam int WIN_SCORE_MIN     = 1;
  localparam int WIN_SCORE_MAX     = 3;
  localparam int DEFAULT_WIN_SCORE = 3;

  // Score belonging to the given player; player 1 for anything but P2.
  function automatic logic [1:0] score_of(input player_t who,
                                          input logic [1:0] s1,
                                          input logic [1:0] s2);
    return (who == PLAYER_P2) ? s2 : s1;
  endfunction

endpackage

// File: rtl/match_ctl_if.sv
// Bundle between match_ctl and the surrounding game path (user inputs, ball
// controller, HUD). auto_serve exists only when AUTO_SERVE_EN is defined.
interface match_ctl_if;
  import pong_pkg::*;

  // Signalling: mouse_left and button are synchronised levels sampled every
  // pclk; game_rst and auto_serve are single-cycle pulses; all other outputs
  // are registered levels. There is no backpressure anywhere on this bundle.
  logic       mouse_left;
  logic       button;
  logic [1:0] score_p1;
  logic [1:0] score_p2;
  logic       start;
  logic       game_rst;
  phase_t     phase;
  logic       game_over;
  player_t    winner;
  player_t    last_scorer;
`ifdef AUTO_SERVE_EN
  logic       auto_serve;
`endif

  modport master (
    input  mouse_left, button, score_p1, score_p2,
    output start, game_rst, phase, game_over, winner, last_scorer
`ifdef AUTO_SERVE_EN
    , output auto_serve
`endif
  );

  modport slave (
    output mouse_left, button, score_p1, score_p2,
    input  start, game_rst, phase, game_over, winner, last_scorer
`ifdef AUTO_SERVE_EN
    , input auto_serve
`endif
  );

endinterface

// File: rtl/match_ctl_delay_timer.sv
// Loadable down-counter with a registered done flag that is high while the
// count sits at zero; the count holds at zero rather than wrapping.
module delay_timer #(
  parameter int CNT_W = 29
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // done is kept equal to (count == 0) by computing it from the next count.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= value;
      done  <= (value == '0);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
      done  <= (count == CNT_W'(1));
    end else begin
      done  <= 1'b1;
    end
  end

endmodule

// File: rtl/match_ctl.sv
// Match-level sequencer above the ball controller: new game, serve gating,
// point detection, inter-point pause and match over. Optional AUTO_SERVE_EN.
module match_ctl
  import pong_pkg::*;
#(
  parameter int PAUSE_CYCLES  = DEFAULT_PAUSE_CYCLES,
  parameter int WIN_SCORE     = DEFAULT_WIN_SCORE,
`ifdef AUTO_SERVE_EN
  parameter int SERVE_TIMEOUT = DEFAULT_SERVE_TIMEOUT,
`endif
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic         pclk,
  input  logic         rst_n,
  match_ctl_if.master  bus
);

  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [1:0]       WIN_CODE   = 2'(WIN_SCORE);
`ifdef AUTO_SERVE_EN
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TIMEOUT - 1);
`endif

  phase_t           state, state_d;
  logic             start_q, game_rst_q, game_over_q;
  player_t          winner_q, last_scorer_q;
  logic [1:0]       prev_p1, prev_p2;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_value;
  logic             p1_chg, p2_chg;
  logic [1:0]       scorer_score;
`ifdef AUTO_SERVE_EN
  logic             auto_q, auto_d;
`endif

  assign p1_chg       = (bus.score_p1 != prev_p1);
  assign p2_chg       = (bus.score_p2 != prev_p2);
  assign scorer_score = score_of(last_scorer_q, prev_p1, prev_p2);

  // Pause and serve timeout never overlap, so one counter serves both.
  delay_timer #(.CNT_W(CNT_W)) u_timer (
    .pclk  (pclk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_comb begin
    state_d   = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
`ifdef AUTO_SERVE_EN
    auto_d    = 1'b0;
`endif
    case (state)
      // Out of reset NEWGAME spends one priming cycle so game_rst still pulses.
      PH_NEWGAME: begin
        if (game_rst_q) begin
          state_d = PH_WAIT_SERVE;
`ifdef AUTO_SERVE_EN
          tmr_load  = 1'b1;
          tmr_value = SERVE_LOAD;
`endif
        end
      end
      PH_WAIT_SERVE: begin
`ifdef AUTO_SERVE_EN
        if (bus.mouse_left || auto_q) begin
          state_d  = PH_RALLY;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          auto_d = 1'b1;
        end
`else
        if (bus.mouse_left) begin
          state_d = PH_RALLY;
        end
`endif
      end
      PH_RALLY: begin
        if (p1_chg || p2_chg) begin
          state_d = PH_POINT;
        end
      end
      PH_POINT: begin
        if (scorer_score == WIN_CODE) begin
          state_d = PH_OVER;
        end else begin
          state_d   = PH_PAUSE;
          tmr_load  = 1'b1;
          tmr_value = PAUSE_LOAD;
        end
      end
      PH_PAUSE: begin
        if (tmr_done) begin
          state_d = PH_WAIT_SERVE;
`ifdef AUTO_SERVE_EN
          tmr_load  = 1'b1;
          tmr_value = SERVE_LOAD;
`endif
        end
      end
      PH_OVER: state_d = PH_OVER;
      default: state_d = PH_NEWGAME;
    endcase

    // New-game request overrides everything else outside NEWGAME.
    if (bus.button && (state != PH_NEWGAME)) begin
      state_d   = PH_NEWGAME;
      tmr_load  = 1'b1;
      tmr_value = '0;
`ifdef AUTO_SERVE_EN
      auto_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state         <= PH_NEWGAME;
      start_q       <= 1'b0;
      game_rst_q    <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= PLAYER_NONE;
      last_scorer_q <= PLAYER_NONE;
      prev_p1       <= 2'd0;
      prev_p2       <= 2'd0;
`ifdef AUTO_SERVE_EN
      auto_q        <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      start_q     <= (state_d == PH_WAIT_SERVE);
      game_rst_q  <= (state_d == PH_NEWGAME);
      game_over_q <= (state_d == PH_OVER);
`ifdef AUTO_SERVE_EN
      auto_q      <= auto_d;
`endif
      // Score copies follow the ball controller except while a new game clears it.
      if (state == PH_NEWGAME) begin
        prev_p1 <= 2'd0;
        prev_p2 <= 2'd0;
      end else begin
        prev_p1 <= bus.score_p1;
        prev_p2 <= bus.score_p2;
      end
      if (state_d == PH_NEWGAME) begin
        winner_q      <= PLAYER_NONE;
        last_scorer_q <= PLAYER_NONE;
      end else begin
        if ((state == PH_RALLY) && (state_d == PH_POINT)) begin
          last_scorer_q <= p1_chg ? PLAYER_P1 : PLAYER_P2;
        end
        if ((state == PH_POINT) && (state_d == PH_OVER)) begin
          winner_q <= last_scorer_q;
        end
      end
    end
  end

  assign bus.phase       = state;
  assign bus.start       = start_q;
  assign bus.game_rst    = game_rst_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.last_scorer = last_scorer_q;
`ifdef AUTO_SERVE_EN
  assign bus.auto_serve  = auto_q;
`endif

endmodule

// File: tb/tb_match_ctl.sv
// Directed bench for match_ctl with PAUSE_CYCLES=10, WIN_SCORE=3 (and
// SERVE_TIMEOUT=20 when AUTO_SERVE_EN is defined); the bench plays ball controller.
module tb_match_ctl;
  import pong_pkg::*;

  logic pclk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [2:0] exp_q[$];

  match_ctl_if bus ();

  match_ctl #(
    .PAUSE_CYCLES  (10),
    .WIN_SCORE     (3),
`ifdef AUTO_SERVE_EN
    .SERVE_TIMEOUT (20),
`endif
    .CNT_W         (8)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] ph, input int budget);
    int n;
    n = 0;
    while (bus.phase != ph && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.phase), 32'(ph));
  endtask

  task automatic count_pause(output int n);
    n = 0;
    while (bus.phase == PH_PAUSE && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int hits;
    logic [2:0] e;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mouse_left = 1'b0;
    bus.button     = 1'b0;
    bus.score_p1   = 2'd0;
    bus.score_p2   = 2'd0;

    // Reset: two cycles low
    tick();
    tick();
    check_eq("rst_phase",       32'(bus.phase), 32'(PH_NEWGAME));
    check_eq("rst_start",       32'(bus.start), 32'd0);
    check_eq("rst_game_rst",    32'(bus.game_rst), 32'd0);
    check_eq("rst_game_over",   32'(bus.game_over), 32'd0);
    check_eq("rst_winner",      32'(bus.winner), 32'(PLAYER_NONE));
    check_eq("rst_last_scorer", 32'(bus.last_scorer), 32'(PLAYER_NONE));
    rst_n = 1'b1;

    tick();
    check_eq("ng_game_rst", 32'(bus.game_rst), 32'd1);
    check_eq("ng_phase",    32'(bus.phase), 32'(PH_NEWGAME));
    tick();
    check_eq("ws_phase",    32'(bus.phase), 32'(PH_WAIT_SERVE));
    check_eq("ws_start",    32'(bus.start), 32'd1);
    check_eq("ws_game_rst", 32'(bus.game_rst), 32'd0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.game_rst) hits++;
    end
    check_eq("game_rst_extra", 32'(hits), 32'd0);
    check_eq("ws_hold", 32'(bus.phase), 32'(PH_WAIT_SERVE));

    // Serve then a player-1 point
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
    check_eq("serve_start", 32'(bus.start), 32'd0);
    check_eq("serve_phase", 32'(bus.phase), 32'(PH_RALLY));
    bus.score_p1 = 2'd1;
    tick();
    check_eq("pt1_phase",  32'(bus.phase), 32'(PH_POINT));
    check_eq("pt1_scorer", 32'(bus.last_scorer), 32'(PLAYER_P1));
    tick();
    check_eq("pause_start", 32'(bus.start), 32'd0);
    count_pause(n);
    check_eq("pause_len1",  32'(n), 32'd10);
    check_eq("pause_exit1", 32'(bus.phase), 32'(PH_WAIT_SERVE));

    // Match to player 2; first pause with mouse_left held throughout
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
    bus.score_p2 = 2'd1;
    tick();
    check_eq("p2a_phase",  32'(bus.phase), 32'(PH_POINT));
    check_eq("p2a_scorer", 32'(bus.last_scorer), 32'(PLAYER_P2));
    bus.mouse_left = 1'b1;
    tick();
    count_pause(n);
    check_eq("pause_len_mouse",  32'(n), 32'd10);
    check_eq("pause_exit_mouse", 32'(bus.phase), 32'(PH_WAIT_SERVE));
    tick();
    check_eq("rally_after_pause", 32'(bus.phase), 32'(PH_RALLY));
    bus.mouse_left = 1'b0;
    bus.score_p2 = 2'd2;
    tick();
    check_eq("p2b_phase", 32'(bus.phase), 32'(PH_POINT));
    wait_phase("p2b_wait_serve", PH_WAIT_SERVE, 30);
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
    bus.score_p2 = 2'd3;
    tick();
    check_eq("p2c_phase", 32'(bus.phase), 32'(PH_POINT));
    tick();
    check_eq("over_phase",     32'(bus.phase), 32'(PH_OVER));
    check_eq("over_game_over", 32'(bus.game_over), 32'd1);
    check_eq("over_winner",    32'(bus.winner), 32'(PLAYER_P2));
    bus.mouse_left = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.mouse_left = 1'b0;
    check_eq("over_ignores_mouse", 32'(bus.phase), 32'(PH_OVER));
    check_eq("over_start",         32'(bus.start), 32'd0);
    check_eq("over_winner_held",   32'(bus.winner), 32'(PLAYER_P2));

    // New game from OVER, score change outside RALLY, then button vs point
    bus.button = 1'b1;
    tick();
    bus.button = 1'b0;
    check_eq("btn_over_phase",    32'(bus.phase), 32'(PH_NEWGAME));
    check_eq("btn_over_game_rst", 32'(bus.game_rst), 32'd1);
    check_eq("btn_over_winner",   32'(bus.winner), 32'(PLAYER_NONE));
    check_eq("btn_over_gover",    32'(bus.game_over), 32'd0);
    bus.score_p1 = 2'd0;
    bus.score_p2 = 2'd0;
    tick();
    check_eq("btn_over_ws", 32'(bus.phase), 32'(PH_WAIT_SERVE));
    bus.score_p1 = 2'd1;
    tick();
    check_eq("score_outside_rally", 32'(bus.phase), 32'(PH_WAIT_SERVE));
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
    check_eq("rally2_phase", 32'(bus.phase), 32'(PH_RALLY));
    bus.button   = 1'b1;
    bus.score_p1 = 2'd2;
    tick();
    check_eq("prio_phase",    32'(bus.phase), 32'(PH_NEWGAME));
    check_eq("prio_game_rst", 32'(bus.game_rst), 32'd1);
    check_eq("prio_scorer",   32'(bus.last_scorer), 32'(PLAYER_NONE));
    bus.score_p1 = 2'd0;

    // Button held: NEWGAME and WAIT_SERVE alternate
    exp_q.push_back(PH_WAIT_SERVE);
    exp_q.push_back(PH_NEWGAME);
    exp_q.push_back(PH_WAIT_SERVE);
    exp_q.push_back(PH_NEWGAME);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check_eq("hold_phase",    32'(bus.phase), 32'(e));
      check_eq("hold_game_rst", 32'(bus.game_rst), 32'(e == PH_NEWGAME));
    end
    bus.button = 1'b0;
    tick();
    tick();
    check_eq("release_phase", 32'(bus.phase), 32'(PH_WAIT_SERVE));
    check_eq("release_start", 32'(bus.start), 32'd1);

`ifdef AUTO_SERVE_EN
    // Auto serve after 20 idle WAIT_SERVE cycles
    bus.button = 1'b1;
    tick();
    bus.button = 1'b0;
    tick();
    n = 0;
    while (!bus.auto_serve && n < 40) begin
      tick();
      n++;
    end
    check_eq("auto_delay", 32'(n), 32'd20);
    tick();
    check_eq("auto_pulse_len", 32'(bus.auto_serve), 32'd0);
    check_eq("auto_rally",     32'(bus.phase), 32'(PH_RALLY));
    // Real serve at cycle 5 suppresses the auto pulse
    bus.button = 1'b1;
    tick();
    bus.button = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.mouse_left = 1'b1;
    tick();
    bus.mouse_left = 1'b0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.auto_serve) hits++;
      tick();
    end
    check_eq("auto_suppressed", 32'(hits), 32'd0);
    check_eq("manual_rally",    32'(bus.phase), 32'(PH_RALLY));
`else
    // Without auto serve WAIT_SERVE waits indefinitely
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.phase != PH_WAIT_SERVE) hits++;
    end
    check_eq("ws_indefinite", 32'(hits), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/match_ctl.md
Name: match_ctl

Overview:
- Match-level sequencer above the ball controller.
- Owns game phase: new-game reset, serve gating, point detection, inter-point pause, and match-over/winner.
- Drives the ball controller's `start` and `button` inputs.
- Watches the ball controller's `score_p1`/`score_p2` to detect points.
- Sits in the top-level game path between user inputs (mouse, button) and the ball controller.

Parameters:
- PAUSE_CYCLES, 65000000: cycles held in PAUSE after a point (1 s at 65 MHz pclk); min 1.
- WIN_SCORE, 3: score that ends the match; legal 1..3 because scores are 2 bits.
- SERVE_TIMEOUT, 325000000: cycles in WAIT_SERVE before an automatic serve; used only with AUTO_SERVE_EN.
- CNT_W, 29: timer width; must hold max(PAUSE_CYCLES, SERVE_TIMEOUT).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mouse_left  in  1  serve request, level, already synchronised.
- button  in  1  new-game request, level, already synchronised.
- score_p1  in  2  player-1 score from the ball controller.
- score_p2  in  2  player-2 score from the ball controller.
- start  out  1  serve enable to the ball controller.
- game_rst  out  1  one-cycle pulse to the ball controller's button input; clears its scores.
- phase  out  3  current state code, for the HUD.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- last_scorer  out  2  same encoding as winner; scorer of the most recent point.
- auto_serve  out  1  only with AUTO_SERVE_EN; one-cycle serve pulse.

Behaviour:
- Reset: the cycle after pclk with rst_n=0:
  - state=NEWGAME.
  - start=0, game_rst=0, game_over=0, winner=00, last_scorer=00, timer=0, prev scores=0.
- All outputs are registered; each is a function of the current state and registers only.
- States, with phase codes:
  - NEWGAME (0):
    - game_rst=1 for exactly this one cycle.
    - Clears prev scores, winner and last_scorer.
    - Next: WAIT_SERVE.
  - WAIT_SERVE (1):
    - start=1.
    - On mouse_left=1: go to RALLY, registering start=0 on the same edge.
  - RALLY (2):
    - start=0.
    - Each cycle compare (score_p1,score_p2) against registered prev copies.
    - A change means a point; last_scorer is set to the side whose score changed.
    - Next state is POINT. prev copies update on that edge.
  - POINT (3): single cycle.
    - If the scorer's score == WIN_SCORE: go to OVER and set winner=last_scorer.
    - Else: load timer=PAUSE_CYCLES-1 and go to PAUSE.
  - PAUSE (4):
    - start=0.
    - Timer decrements each cycle; at 0, go to WAIT_SERVE.
    - mouse_left is ignored here.
  - OVER (5):
    - game_over=1, start=0, winner held.
    - Only button leaves this state.
- Priority rules:
  - button=1 in any state except NEWGAME forces NEWGAME next cycle. This beats a simultaneous score change, timer expiry, or mouse_left.
  - button held high: the block re-enters NEWGAME every other cycle (NEWGAME→WAIT_SERVE→NEWGAME…). Each NEWGAME entry pulses game_rst. WAIT_SERVE is held once button falls.
- Both scores changing in the same cycle is illegal input. If it happens, last_scorer=01 (player 1 wins the tie).
- A score change outside RALLY updates the prev copies and is otherwise ignored. No state change.
- Saturation: the ball controller saturates at 3. With WIN_SCORE=3 the match ends before saturation.
- Timer: unsigned CNT_W bits, no wrap; it holds at 0 outside PAUSE and serve-timeout use.
- Latency:
  - mouse_left to start=0: 1 cycle.
  - Score change to phase=POINT: 1 cycle.
  - POINT to PAUSE: 1 cycle.
  - Pause length: exactly PAUSE_CYCLES cycles in PAUSE.

Optional Feature:
- Macro: AUTO_SERVE_EN.
- Defined:
  - On WAIT_SERVE entry, load timer=SERVE_TIMEOUT-1 and decrement each cycle.
  - At 0, assert auto_serve for one cycle and go to RALLY as if mouse_left had been seen.
  - The top level ORs auto_serve into the ball controller's mouse_left.
  - A real mouse_left before expiry wins and suppresses auto_serve.
- Undefined: the auto_serve port and SERVE_TIMEOUT logic are absent; WAIT_SERVE waits indefinitely.

Decomposition:
- pong_pkg holds:
  - phase codes NEWGAME..OVER.
  - player codes PLAYER_NONE/P1/P2.
  - default PAUSE_CYCLES.
  - WIN_SCORE limits.
- Sub-module delay_timer: loadable CNT_W down-counter with `load`, `value` and a registered `done` flag at 0. It is shared by the pause and serve-timeout functions, since these never overlap in time.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → game_rst pulses in exactly one cycle; phase=1 and start=1 on the next cycle.
- Serve then point: mouse_left=1 in WAIT_SERVE → start=0 next cycle, phase=2. Then score_p1 goes 0→1 → phase=3, last_scorer=01. With PAUSE_CYCLES=10, phase=4 for exactly 10 cycles, then phase=1.
- Match end, WIN_SCORE=3: drive score_p2 to 3 across three rallies → after the third point, phase=5, game_over=1, winner=10. mouse_left is then ignored.
- Button priority: button=1 in the same cycle as a score_p1 change in RALLY → phase=0 and game_rst=1 next cycle; last_scorer=00.
- PAUSE immunity: mouse_left=1 throughout PAUSE → still exactly PAUSE_CYCLES cycles in PAUSE, then WAIT_SERVE, then RALLY one cycle later.
- AUTO_SERVE_EN with SERVE_TIMEOUT=20:
  - With no mouse input, auto_serve pulses once, 20 cycles after WAIT_SERVE entry; phase=2 next cycle.
  - With mouse_left at cycle 5, auto_serve never pulses.
